fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage sitting directly upstream of the instruction ROM (`instr`) and feeding the decode/register-fetch stage. It owns the program counter and drives the word-aligned fetch address to the ROM, which returns the instruction combinationally in the same cycle. It registers that instruction into the IF/RF pipeline register and handles stall, branch/jump redirect, illegal-op trap and interrupt entry. It also tracks supervisor mode and produces the exception-pointer (r30) writeback value.

Parameters:
RESET_ADDR, 32'd0, PC value after reset (program selector entry).
ILLOP_ADDR, 32'd504, trap vector for illegal opcodes (second-to-last ROM word).
XADR_ADDR, 32'd508, interrupt vector (last ROM word).
NOP_INSTR, 32'h83FFF800, bubble encoding, ADD(r31,r31,r31).

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
pc  out  32  fetch address to `instr`: {1'b0, PC[30:2], 2'b00}
id  in  32  instruction returned by `instr` for `pc` (combinational)
stall  in  1  decode cannot accept; hold PC and IF/RF register
redirect_valid  in  1  taken branch/JMP resolved in decode this cycle
redirect_target  in  32  new PC; bit31 = supervisor bit of target
illop  in  1  decode flags the current if_instr as an illegal opcode
irq  in  1  level-sensitive interrupt request
if_valid  out  1  if_instr/if_pc are a real instruction
if_instr  out  32  registered instruction (NOP_INSTR when invalid)
if_pc_plus4  out  32  registered address+4 of if_instr (BR linkage)
xp_we  out  1  one-cycle pulse: write xp_data into r30
xp_data  out  32  saved return address for r30
supervisor  out  1  current mode bit (PC[31])

Behaviour:
- Reset (has priority over everything, any cycle including mid-stall or mid-redirect): PC<=RESET_ADDR with bit31=1, supervisor=1, if_valid=0, if_instr=NOP_INSTR, if_pc_plus4=0, xp_we=0, xp_data=0.
- Next-PC priority each cycle: reset > illop > redirect_valid > irq accept > stall > sequential.
- Sequential (no event, stall=0): PC<=PC+4; IF/RF <= {valid=1, id, PC+4}. Arithmetic is 31-bit on PC[30:0] and wraps 0x7FFFFFFC->0; bit31 is preserved.
- stall=1 with no higher event: PC, if_valid, if_instr, if_pc_plus4 all hold; `pc` output is unchanged, so the ROM output is stable.
- redirect_valid: PC<=redirect_target with [1:0] forced to 00. Bit31 of the new PC = redirect_target[31] AND current supervisor, so user mode can never enter supervisor. The IF/RF register is loaded with a bubble to squash the wrong-path fetch. Redirect overrides stall.
- illop: PC<=ILLOP_ADDR|bit31=1. IF/RF gets a bubble. xp_we=1 for one cycle with xp_data=if_pc_plus4 (the address of the instruction after the illegal one). Overrides redirect and stall. Taken regardless of mode.
- irq accept: the request is accepted only when irq=1, supervisor=0, stall=0, illop=0 and redirect_valid=0. On accept: PC<=XADR_ADDR|bit31=1; the instruction fetched this cycle is squashed (IF/RF bubble); xp_we=1 with xp_data=PC+4 (the squashed address +4, Beta convention). The irq level is held off (not lost) while it is blocked.
- supervisor output mirrors PC[31] combinationally from the register. It returns to 0 only via a redirect whose target bit31 is 0.
- xp_we is deasserted in every cycle without an illop or irq accept. xp_data holds its last value.
- Latency: an instruction at address A appears on if_instr one cycle after pc==A. The first valid instruction after reset release appears one cycle later (pc=RESET_ADDR in the first non-reset cycle).
- Simultaneous illop+irq: illop taken. irq is re-evaluated next cycle and is blocked because supervisor=1.

Test Plan:
- Reset then run with stall=0: pc steps 0,4,8,… Cycle 1 gives if_valid=1, if_instr=ROM[0], if_pc_plus4=4. supervisor=1 throughout.
- Stall held 3 cycles at pc=8: pc, if_instr and if_pc_plus4 are frozen. On release, pc=12 next cycle.
- redirect_valid with target 0x000000C9 while stall=1 in supervisor: pc=0xC8, supervisor=0, next if_valid=0 (bubble), then ROM[50].
- User mode at pc=0x110, irq=1: next pc=XADR(508), supervisor=1, xp_we pulse with xp_data=0x114, one bubble. irq held high afterwards: no re-entry.
- illop and redirect same cycle with if_pc_plus4=0x20: pc=504, xp_data=0x20, redirect ignored. A user-mode redirect target with bit31=1 keeps supervisor=0.
- Assert reset mid-redirect/irq cycle: next pc=RESET_ADDR, if_valid=0, xp_we=0, supervisor=1.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the Beta pipeline.
// This stage owns the program counter. It drives the word-aligned fetch
// address to the instruction ROM and registers the returned word into the
// IF/RF pipeline register. It also handles stall, redirect, illegal-op trap
// and interrupt entry, and produces the r30 (XP) writeback.
//
// Fetch events, highest priority first:
//   event    | meaning
//   EV_ILLOP | decode trapped the current if_instr; vector to ILLOP_ADDR
//   EV_REDIR | taken branch/JMP from decode; squash the wrong-path fetch
//   EV_IRQ   | interrupt accepted in user mode; vector to XADR_ADDR
//   EV_STALL | decode busy; freeze PC and IF/RF
//   EV_SEQ   | normal sequential fetch, PC += 4
module fetch_stage #(
  parameter logic [31:0] RESET_ADDR = 32'd0,
  parameter logic [31:0] ILLOP_ADDR = 32'd504,
  parameter logic [31:0] XADR_ADDR  = 32'd508,
  parameter logic [31:0] NOP_INSTR  = 32'h83FFF800
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc,
  input  logic [31:0] id,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        illop,
  input  logic        irq,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_plus4,
  output logic        xp_we,
  output logic [31:0] xp_data,
  output logic        supervisor
);

  typedef enum logic [2:0] {
    EV_SEQ   = 3'd0,
    EV_STALL = 3'd1,
    EV_IRQ   = 3'd2,
    EV_REDIR = 3'd3,
    EV_ILLOP = 3'd4
  } fetch_event_t;

  localparam logic [31:0] SUP_BIT   = 32'h8000_0000;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  // Vectors always enter supervisor mode and are forced word aligned.
  localparam logic [31:0] RESET_PC = (RESET_ADDR | SUP_BIT) & WORD_MASK;
  localparam logic [31:0] ILLOP_PC = (ILLOP_ADDR | SUP_BIT) & WORD_MASK;
  localparam logic [31:0] XADR_PC  = (XADR_ADDR  | SUP_BIT) & WORD_MASK;

  // Architectural state.
  logic [31:0] r_pc;
  logic        r_if_valid;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc_plus4;
  logic        r_xp_we;
  logic [31:0] r_xp_data;

  // Combinational next-state.
  fetch_event_t w_event;
  logic [31:0]  w_fetch_addr;
  logic [31:0]  w_pc_plus4;
  logic [31:0]  w_pc_next;
  logic         w_load_ifrf;
  logic         w_bubble;
  logic         w_xp_we_next;
  logic [31:0]  w_xp_data_next;
  logic         w_irq_accept;

  // Fetch address and its 31-bit incremented successor (wraps, no mode bit).
  always_comb begin
    w_fetch_addr = {1'b0, r_pc[30:0] & 31'h7FFF_FFFC};
    w_pc_plus4   = {1'b0, w_fetch_addr[30:0] + 31'd4};
  end

  // Pick the single winning event for this cycle by priority.
  always_comb begin
    // An interrupt can only be taken from user mode in a cycle that would
    // otherwise fetch sequentially; if blocked the level simply waits.
    w_irq_accept = irq & ~r_pc[31] & ~stall & ~illop & ~redirect_valid;
    w_event      = EV_SEQ;
    if (illop) begin
      w_event = EV_ILLOP;
    end else if (redirect_valid) begin
      w_event = EV_REDIR;
    end else if (w_irq_accept) begin
      w_event = EV_IRQ;
    end else if (stall) begin
      w_event = EV_STALL;
    end
  end

  // Next PC, IF/RF load control and XP writeback for the chosen event.
  always_comb begin
    w_pc_next      = {r_pc[31], w_pc_plus4[30:0]};
    w_load_ifrf    = 1'b1;
    w_bubble       = 1'b0;
    w_xp_we_next   = 1'b0;
    w_xp_data_next = r_xp_data;
    unique case (w_event)
      EV_ILLOP: begin
        w_pc_next      = ILLOP_PC;
        w_bubble       = 1'b1;
        w_xp_we_next   = 1'b1;
        w_xp_data_next = r_if_pc_plus4;
      end
      EV_REDIR: begin
        // User code can never promote itself into supervisor mode.
        w_pc_next = {redirect_target[31] & r_pc[31],
                     redirect_target[30:0] & 31'h7FFF_FFFC};
        w_bubble  = 1'b1;
      end
      EV_IRQ: begin
        // The word fetched this cycle is squashed; XP returns to it + 4.
        w_pc_next      = XADR_PC;
        w_bubble       = 1'b1;
        w_xp_we_next   = 1'b1;
        w_xp_data_next = w_pc_plus4;
      end
      EV_STALL: begin
        w_pc_next   = r_pc;
        w_load_ifrf = 1'b0;
      end
      default: begin
        w_pc_next = {r_pc[31], w_pc_plus4[30:0]};
      end
    endcase
  end

  // PC register; reset wins over every event.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // IF/RF pipeline register: load the ROM word, a bubble, or hold on stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_if_valid    <= 1'b0;
      r_if_instr    <= NOP_INSTR;
      r_if_pc_plus4 <= 32'd0;
    end else if (w_bubble) begin
      r_if_valid    <= 1'b0;
      r_if_instr    <= NOP_INSTR;
      r_if_pc_plus4 <= 32'd0;
    end else if (w_load_ifrf) begin
      r_if_valid    <= 1'b1;
      r_if_instr    <= id;
      r_if_pc_plus4 <= w_pc_plus4;
    end
  end

  // XP writeback: single-cycle strobe, data held between traps.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_xp_we   <= 1'b0;
      r_xp_data <= 32'd0;
    end else begin
      r_xp_we   <= w_xp_we_next;
      r_xp_data <= w_xp_data_next;
    end
  end

  // Output mapping.
  always_comb begin
    pc          = w_fetch_addr;
    supervisor  = r_pc[31];
    if_valid    = r_if_valid;
    if_instr    = r_if_instr;
    if_pc_plus4 = r_if_pc_plus4;
    xp_we       = r_xp_we;
    xp_data     = r_xp_data;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a
// behavioural model of the fetch rules, with a 128-word random ROM.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h83FFF800;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] id;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        illop;
  logic        irq;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;
  logic        xp_we;
  logic [31:0] xp_data;
  logic        supervisor;

  logic [31:0] rom [128];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model state: full PC (bit31 = mode) plus the visible registers.
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pp4;
  logic        m_xpwe;
  logic [31:0] m_xpdata;

  fetch_stage dut (
    .clk(clk), .reset(reset), .pc(pc), .id(id), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .illop(illop), .irq(irq), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc_plus4(if_pc_plus4), .xp_we(xp_we), .xp_data(xp_data),
    .supervisor(supervisor)
  );

  always #5 clk = ~clk;

  assign id = rom[pc[8:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Apply the rules for one rising edge, using the inputs in effect.
  task automatic model_step();
    logic [31:0] addr;
    logic [31:0] plus4;
    logic        sup;
    if (reset) begin
      m_pc = 32'h8000_0000; m_valid = 1'b0; m_instr = NOP; m_pp4 = 32'd0;
      m_xpwe = 1'b0; m_xpdata = 32'd0;
    end else begin
      addr   = m_pc & 32'h7FFF_FFFC;
      plus4  = (addr + 32'd4) & 32'h7FFF_FFFF;
      sup    = m_pc[31];
      m_xpwe = 1'b0;
      if (illop) begin
        m_xpwe = 1'b1; m_xpdata = m_pp4;
        m_pc = 32'h8000_0000 + 32'd504;
        m_valid = 1'b0; m_instr = NOP;
      end else if (redirect_valid) begin
        m_pc = (redirect_target & 32'h7FFF_FFFC) | ((redirect_target[31] && sup) ? 32'h8000_0000 : 32'd0);
        m_valid = 1'b0; m_instr = NOP;
      end else if (irq && !sup && !stall) begin
        m_xpwe = 1'b1; m_xpdata = plus4;
        m_pc = 32'h8000_0000 + 32'd508;
        m_valid = 1'b0; m_instr = NOP;
      end else if (!stall) begin
        m_valid = 1'b1; m_instr = rom[addr[8:2]]; m_pp4 = plus4;
        m_pc = plus4 | (sup ? 32'h8000_0000 : 32'd0);
      end
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, land on the falling edge.
  task automatic cyc(input logic r, input logic st, input logic rv,
                     input logic [31:0] rt, input logic il, input logic iq);
    reset = r; stall = st; redirect_valid = rv; redirect_target = rt;
    illop = il; irq = iq;
    @(posedge clk);
    model_step();
    chk_en = 1'b1;
    @(negedge clk);
  endtask

  // Compare process: every falling edge once the model is initialised.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", pc, m_pc & 32'h7FFF_FFFC);
      chk("supervisor", {31'd0, supervisor}, {31'd0, m_pc[31]});
      chk("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
      chk("if_instr", if_instr, m_instr);
      if (m_valid) chk("if_pc_plus4", if_pc_plus4, m_pp4);
      chk("xp_we", {31'd0, xp_we}, {31'd0, m_xpwe});
      chk("xp_data", xp_data, m_xpdata);
    end
  end

  initial begin
    logic [31:0] t;
    logic        st, rv, il, iq, r;
    for (int i = 0; i < 128; i++) rom[i] = $urandom;
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0;
    illop = 1'b0; irq = 1'b0;
    @(negedge clk);

    // Reset state.
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_sup", {31'd0, supervisor}, 32'd1);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, NOP);
    chk("rst_xpwe", {31'd0, xp_we}, 32'd0);

    // Sequential run from reset.
    cyc(0, 0, 0, 0, 0, 0);
    chk("seq_pc", pc, 32'd4);
    chk("seq_valid", {31'd0, if_valid}, 32'd1);
    chk("seq_instr", if_instr, rom[0]);
    chk("seq_pp4", if_pc_plus4, 32'd4);
    cyc(0, 0, 0, 0, 0, 0);
    chk("seq_pc8", pc, 32'd8);

    // Stall three cycles at pc=8.
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0, 0, 0);
      chk("stall_pc", pc, 32'd8);
      chk("stall_pp4", if_pc_plus4, 32'd8);
      chk("stall_instr", if_instr, rom[1]);
    end
    cyc(0, 0, 0, 0, 0, 0);
    chk("unstall_pc", pc, 32'd12);

    // Redirect during stall into user mode.
    cyc(0, 1, 1, 32'h0000_00C9, 0, 0);
    chk("redir_pc", pc, 32'h0000_00C8);
    chk("redir_sup", {31'd0, supervisor}, 32'd0);
    chk("redir_bubble", {31'd0, if_valid}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("redir_instr", if_instr, rom[50]);
    chk("redir_pc2", pc, 32'h0000_00CC);

    // Interrupt from user mode at 0x110.
    cyc(0, 0, 1, 32'h0000_0110, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("irq_pc", pc, 32'd508);
    chk("irq_sup", {31'd0, supervisor}, 32'd1);
    chk("irq_xpwe", {31'd0, xp_we}, 32'd1);
    chk("irq_xpdata", xp_data, 32'h0000_0114);
    chk("irq_bubble", {31'd0, if_valid}, 32'd0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("irq_noreentry_we", {31'd0, xp_we}, 32'd0);
    chk("irq_noreentry_pc", pc, 32'h0000_0200);

    // illop beats redirect; xp_data comes from if_pc_plus4.
    cyc(0, 0, 1, 32'h8000_001C, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("pre_illop_pp4", if_pc_plus4, 32'h0000_0020);
    cyc(0, 0, 1, 32'h8000_0040, 1, 0);
    chk("illop_pc", pc, 32'd504);
    chk("illop_xpdata", xp_data, 32'h0000_0020);
    chk("illop_xpwe", {31'd0, xp_we}, 32'd1);

    // User-mode target with bit31 set stays in user mode.
    cyc(0, 0, 1, 32'h0000_0100, 0, 0);
    cyc(0, 0, 1, 32'h8000_0040, 0, 0);
    chk("user_redir_pc", pc, 32'h0000_0040);
    chk("user_redir_sup", {31'd0, supervisor}, 32'd0);

    // Reset during a redirect+irq cycle.
    cyc(1, 0, 1, 32'h0000_0080, 0, 1);
    chk("rst_mid_pc", pc, 32'd0);
    chk("rst_mid_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_mid_xpwe", {31'd0, xp_we}, 32'd0);
    chk("rst_mid_sup", {31'd0, supervisor}, 32'd1);

    // PC wrap at the top of the 31-bit space.
    cyc(0, 0, 1, 32'h7FFF_FFFC, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("wrap_pc", pc, 32'd0);
    chk("wrap_pp4", if_pc_plus4, 32'd0);

    // Randomized traffic.
    iq = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      st = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 7) == 0);
      il = m_valid && ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0) iq = ~iq;
      case ($urandom_range(0, 15))
        0:       t = 32'h7FFF_FFF8 | ($urandom & 32'h8000_0007);
        1:       t = $urandom;
        default: t = ($urandom_range(0, 127) * 4) | ($urandom & 32'h8000_0003);
      endcase
      cyc(r, st, rv, t, il, iq);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
